// File: rtl/preif_if_buf.sv
// Elastic DEPTH-entry buffer between the pre-IF and IF stages.
// Carries {addr, data, compressed}; drops the reset-address bubble and supports synchronous flush.
module preif_if_buf #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(32'h8000_0000),
  parameter logic [DATA_W-1:0] NOP_DATA   = DATA_W'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ADDR_W-1:0]          in_addr_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_compressed_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDR_W-1:0]          out_addr_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_compressed_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BUBBLE_ADDR = RESET_ADDR - ADDR_W'(4);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              comp_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic bubble;
  logic wr_en;

  // Ready is a pure function of occupancy, so a pop from full cannot free a slot in the same cycle.
  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign count_o     = count;

  always_comb begin
    push   = in_valid_i & in_ready_o & ~flush_i;
    pop    = out_valid_o & out_ready_i & ~flush_i;
    bubble = (in_addr_i == BUBBLE_ADDR);
    wr_en  = push & ~bubble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is only ever read behind a valid count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= in_addr_i;
      data_mem[wr_ptr] <= in_data_i;
      comp_mem[wr_ptr] <= in_compressed_i;
    end
  end

  always_comb begin
    out_addr_o       = '0;
    out_data_o       = NOP_DATA;
    out_compressed_o = 1'b0;
    if (out_valid_o) begin
      out_addr_o       = addr_mem[rd_ptr];
      out_data_o       = data_mem[rd_ptr];
      out_compressed_o = comp_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_preif_if_buf.sv
// Directed bench for preif_if_buf (DEPTH=2): reset, backpressure, streaming wrap, bubble, flush, compressed flag.
module tb_preif_if_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_addr_i;
  logic [31:0] in_data_i;
  logic        in_compressed_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_data_o;
  logic        out_compressed_o;
  logic [1:0]  count_o;

  int total = 0;
  int passed = 0;

  preif_if_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_addr_i        (in_addr_i),
    .in_data_i        (in_data_i),
    .in_compressed_i  (in_compressed_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_addr_o       (out_addr_o),
    .out_data_o       (out_data_o),
    .out_compressed_o (out_compressed_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] a, input logic [31:0] d, input logic c);
    in_valid_i      = v;
    in_addr_i       = a;
    in_data_i       = d;
    in_compressed_i = c;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_data", out_data_o, 32'h13);
    check("rst_addr", out_addr_o, 0);
    check("rst_comp", out_compressed_o, 0);
    rst = 1'b0;

    // Fill to two entries, then reset asynchronously mid-cycle.
    offer(1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0);
    step();
    offer(1'b1, 32'h8000_0004, 32'h0000_1111, 1'b0);
    step();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    check("pre_rst_count", count_o, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_ready", in_ready_o, 1);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_data", out_data_o, 32'h13);
    #1 rst = 1'b0;
    step();

    // First push after reset: not visible before the edge, visible after.
    offer(1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0);
    #1;
    check("no_bypass_valid", out_valid_o, 0);
    step();
    check("first_valid", out_valid_o, 1);
    check("first_addr", out_addr_o, 32'h8000_0000);
    check("first_data", out_data_o, 32'h0000_0297);
    check("first_count", count_o, 1);

    // Backpressure: fill, then a third offer waits.
    offer(1'b1, 32'h8000_0004, 32'h0000_0aaa, 1'b0);
    step();
    check("full_count", count_o, 2);
    check("full_ready", in_ready_o, 0);
    offer(1'b1, 32'h8000_0008, 32'h0000_0bbb, 1'b0);
    step();
    check("hold_count", count_o, 2);
    check("hold_addr", out_addr_o, 32'h8000_0000);
    check("hold_data", out_data_o, 32'h0000_0297);
    out_ready_i = 1'b1;
    step();
    check("pop_a_head", out_addr_o, 32'h8000_0004);
    check("pop_a_count", count_o, 1);
    check("pop_a_ready", in_ready_o, 1);
    step();
    check("pop_b_head", out_addr_o, 32'h8000_0008);
    check("pop_b_data", out_data_o, 32'h0000_0bbb);
    check("pop_b_count", count_o, 1);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check("drain_valid", out_valid_o, 0);
    check("drain_count", count_o, 0);

    // Streaming at count=1 across pointer wrap.
    out_ready_i = 1'b0;
    offer(1'b1, 32'h8000_0100, 32'h0000_1000, 1'b0);
    step();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'h8000_0100 + 32'(4 * i), 32'h0000_1000 + 32'(i), 1'b0);
      step();
      check($sformatf("stream_addr_%0d", i), out_addr_o, 32'h8000_0100 + 32'(4 * i));
      check($sformatf("stream_cnt_%0d", i), count_o, 1);
    end
    check("stream_last_data", out_data_o, 32'h0000_1008);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check("stream_empty", out_valid_o, 0);

    // Bubble at RESET_ADDR-4.
    out_ready_i = 1'b0;
    offer(1'b1, 32'h7FFF_FFFC, 32'h0000_dead, 1'b0);
    #1;
    check("bubble_ready", in_ready_o, 1);
    step();
    check("bubble_count", count_o, 0);
    check("bubble_valid", out_valid_o, 0);

    // Flush at count=2 with a concurrent offer.
    offer(1'b1, 32'h8000_0200, 32'h0000_2000, 1'b0);
    step();
    offer(1'b1, 32'h8000_0204, 32'h0000_2004, 1'b0);
    step();
    check("pre_flush_count", count_o, 2);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    offer(1'b1, 32'h8000_0010, 32'h0000_0010, 1'b0);
    step();
    check("flush2_count", count_o, 0);
    check("flush2_valid", out_valid_o, 0);
    // Flush at count=1 where the offer would otherwise be accepted.
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    offer(1'b1, 32'h8000_0300, 32'h0000_3000, 1'b0);
    step();
    check("pre_flush1_count", count_o, 1);
    flush_i = 1'b1;
    offer(1'b1, 32'h8000_0010, 32'h0000_0010, 1'b0);
    step();
    flush_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    check("flush1_count", count_o, 0);
    check("flush1_valid", out_valid_o, 0);
    step();
    check("flush_after_valid", out_valid_o, 0);
    check("flush_after_addr", out_addr_o, 0);

    // Compressed flag follows its own entry only.
    offer(1'b1, 32'h8000_0002, 32'h0000_4501, 1'b1);
    step();
    check("comp_set", out_compressed_o, 1);
    check("comp_data", out_data_o, 32'h0000_4501);
    offer(1'b1, 32'h8000_0004, 32'h00a0_0093, 1'b0);
    step();
    check("comp_hold", out_compressed_o, 1);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    out_ready_i = 1'b1;
    step();
    check("comp_next", out_compressed_o, 0);
    check("comp_next_addr", out_addr_o, 32'h8000_0004);
    step();
    check("end_empty_data", out_data_o, 32'h13);
    check("end_empty_comp", out_compressed_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
